// File: rtl/cv32e40x_pkg.sv
// Shared types for the sequential divider: opcode and FSM encodings plus small
// opcode decode helpers.
package cv32e40x_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_opcode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        INIT   = 2'b01,
        DIVIDE = 2'b10,
        FINISH = 2'b11
    } div_state_e;

    function automatic logic op_is_signed(input div_opcode_e op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic op_is_rem(input div_opcode_e op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/cv32e40x_div_seq_if.sv
// Divider bundle: operand request, result handshake and the borrowed ALU CLZ /
// shifter path. The divider is the slave; the pipeline/ALU side is the master.
interface cv32e40x_div_seq_if;
    import cv32e40x_pkg::*;

    div_opcode_e operator_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        valid_i;
    logic        ready_o;

    logic [31:0] result_o;
    logic        valid_o;
    logic        ready_i;
    logic        kill_i;

    logic        alu_clz_en_o;
    logic [31:0] alu_clz_data_o;
    logic [5:0]  alu_clz_result_i;
    logic        alu_shift_en_o;
    logic [5:0]  alu_shift_amt_o;
    logic [31:0] alu_shift_op_o;
    logic [31:0] alu_shifted_i;

    modport slave (
        input  operator_i, op_a_i, op_b_i, valid_i, ready_i, kill_i,
               alu_clz_result_i, alu_shifted_i,
        output ready_o, result_o, valid_o,
               alu_clz_en_o, alu_clz_data_o, alu_shift_en_o, alu_shift_amt_o, alu_shift_op_o
    );

    modport master (
        output operator_i, op_a_i, op_b_i, valid_i, ready_i, kill_i,
               alu_clz_result_i, alu_shifted_i,
        input  ready_o, result_o, valid_o,
               alu_clz_en_o, alu_clz_data_o, alu_shift_en_o, alu_shift_amt_o, alu_shift_op_o
    );

endinterface

// File: rtl/cv32e40x_div_seq.sv
// Sequential restoring divider: normalises the divisor with the ALU's CLZ and
// shifter, then retires one quotient bit per cycle, clz(divisor)+1 steps in all.
module cv32e40x_div_seq
    import cv32e40x_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    cv32e40x_div_seq_if.slave  div_if
);

    div_state_e  state_q,   state_d;
    div_opcode_e op_q,      op_d;
    logic [31:0] a_abs_q,   a_abs_d;
    logic [31:0] b_abs_q,   b_abs_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] rem_q,     rem_d;
    logic [31:0] quo_q,     quo_d;
    logic [31:0] divisor_q, divisor_d;
    logic [4:0]  cnt_q,     cnt_d;
    logic [31:0] result_q,  result_d;

    // Single shared subtractor: the borrow doubles as the rem >= divisor compare.
    logic        sub_borrow;
    logic [31:0] sub_diff;
    logic        step_ge;
    logic [31:0] rem_step;
    logic [31:0] quo_step;
    logic        in_signed;
    logic [31:0] fin_val;
    logic        fin_neg;
    logic [31:0] fin_result;

    assign {sub_borrow, sub_diff} = {1'b0, rem_q} - {1'b0, divisor_q};
    assign step_ge   = ~sub_borrow;
    assign rem_step  = step_ge ? sub_diff : rem_q;
    assign quo_step  = (quo_q << 1) | {31'b0, step_ge};
    assign in_signed = op_is_signed(div_if.operator_i);

    assign div_if.result_o = result_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a signal unassigned and infer a latch.
        state_d   = state_q;
        op_d      = op_q;
        a_abs_d   = a_abs_q;
        b_abs_d   = b_abs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        cnt_d     = cnt_q;
        result_d  = result_q;

        div_if.ready_o         = 1'b0;
        div_if.valid_o         = 1'b0;
        div_if.alu_clz_en_o    = 1'b0;
        div_if.alu_clz_data_o  = '0;
        div_if.alu_shift_en_o  = 1'b0;
        div_if.alu_shift_op_o  = '0;
        div_if.alu_shift_amt_o = '0;

        // Final value selection; a zero divisor leaves INIT with the fixed results.
        if (state_q == INIT) begin
            fin_val = op_is_rem(op_q) ? a_abs_q : 32'hFFFF_FFFF;
            fin_neg = op_is_rem(op_q) ? neg_rem_q : 1'b0;
        end else begin
            fin_val = op_is_rem(op_q) ? rem_step : quo_step;
            fin_neg = op_is_rem(op_q) ? neg_rem_q : neg_quo_q;
        end
        fin_result = fin_neg ? (~fin_val + 32'd1) : fin_val;

        unique case (state_q)
            IDLE: begin
                div_if.ready_o = 1'b1;
                if (div_if.valid_i && !div_if.kill_i) begin
                    state_d   = INIT;
                    op_d      = div_if.operator_i;
                    a_abs_d   = (in_signed && div_if.op_a_i[31]) ? (~div_if.op_a_i + 32'd1)
                                                                 : div_if.op_a_i;
                    b_abs_d   = (in_signed && div_if.op_b_i[31]) ? (~div_if.op_b_i + 32'd1)
                                                                 : div_if.op_b_i;
                    neg_quo_d = in_signed && (div_if.op_a_i[31] ^ div_if.op_b_i[31]);
                    neg_rem_d = in_signed && div_if.op_a_i[31];
                end
            end
            INIT: begin
                div_if.alu_clz_en_o    = 1'b1;
                div_if.alu_clz_data_o  = b_abs_q;
                div_if.alu_shift_en_o  = 1'b1;
                div_if.alu_shift_op_o  = b_abs_q;
                div_if.alu_shift_amt_o = {1'b0, div_if.alu_clz_result_i[4:0]};
                divisor_d = div_if.alu_shifted_i;
                cnt_d     = div_if.alu_clz_result_i[4:0];
                rem_d     = a_abs_q;
                quo_d     = '0;
                if (div_if.alu_clz_result_i == 6'd32) begin
                    state_d  = FINISH;
                    result_d = fin_result;
                end else begin
                    state_d  = DIVIDE;
                end
            end
            DIVIDE: begin
                rem_d     = rem_step;
                quo_d     = quo_step;
                divisor_d = divisor_q >> 1;
                cnt_d     = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d  = FINISH;
                    result_d = fin_result;
                end
            end
            FINISH: begin
                div_if.valid_o = 1'b1;
                if (div_if.ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (div_if.kill_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= DIV;
            a_abs_q   <= '0;
            b_abs_q   <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of the others, independent of statement order.
            state_q   <= state_d;
            op_q      <= op_d;
            a_abs_q   <= a_abs_d;
            b_abs_q   <= b_abs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
        end
    end

endmodule
